// File: rtl/gen_row_sequencer.sv
// Multi-generation row sequencer for line_buffer: walks calc_row over the frame once per
// generation, supplies neighbour-row indices and edge flags, and ping-pongs the frame buffer.
module gen_row_sequencer #(
    parameter int ROWS  = 720,
    parameter int ROW_W = 10,
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [GEN_W-1:0] num_gens,
    input  logic             wrap_en,
    input  logic             pause,
    input  logic             abort,
    input  logic             row_ack,
    output logic             calc_flag,
    output logic [ROW_W-1:0] calc_row,
    output logic [ROW_W-1:0] row_above,
    output logic [ROW_W-1:0] row_below,
    output logic             top_edge,
    output logic             bottom_edge,
    output logic             buf_sel,
    output logic [GEN_W-1:0] gen_count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, SWAP, FINISH} state_t;

    localparam logic [ROW_W-1:0] LAST = ROW_W'(ROWS - 1);

    state_t           state, state_n;
    logic [GEN_W-1:0] ng_q, ng_n, gen_n;
    logic             wrap_q, wrap_n;
    logic             flag_n, bsel_n, done_n, busy_n, top_n, bot_n;
    logic [ROW_W-1:0] row_n, above_n, below_n;

    always_comb begin
        state_n = state;
        ng_n    = ng_q;
        wrap_n  = wrap_q;
        flag_n  = 1'b0;
        row_n   = calc_row;
        gen_n   = gen_count;
        bsel_n  = buf_sel;
        above_n = '0;
        below_n = '0;
        top_n   = 1'b0;
        bot_n   = 1'b0;

        case (state)
            IDLE: begin
                row_n = '0;
                if (start) begin
                    ng_n   = num_gens;
                    wrap_n = wrap_en;
                    gen_n  = '0;
                    if (num_gens == '0) begin
                        state_n = FINISH;
                    end else begin
                        state_n = RUN;
                        flag_n  = !pause;
                    end
                end
            end
            RUN: begin
                // An ack while paused still retires the row that was already in flight.
                flag_n = !pause;
                if (row_ack) begin
                    if (calc_row == LAST) begin
                        state_n = SWAP;
                        flag_n  = 1'b0;
                        row_n   = '0;
                    end else begin
                        row_n = calc_row + 1'b1;
                    end
                end
            end
            SWAP: begin
                bsel_n = ~buf_sel;
                gen_n  = gen_count + 1'b1;
                row_n  = '0;
                if (gen_n == ng_q) begin
                    state_n = FINISH;
                end else begin
                    state_n = RUN;
                    flag_n  = !pause;
                end
            end
            default: begin
                state_n = IDLE;
                row_n   = '0;
            end
        endcase

        // Abort keeps the last completed buffer and count intact.
        if (abort && state != IDLE) begin
            state_n = IDLE;
            flag_n  = 1'b0;
            row_n   = '0;
            gen_n   = gen_count;
            bsel_n  = buf_sel;
        end

        done_n = (state_n == FINISH);
        busy_n = (state_n != IDLE);

        if (state_n == RUN || state_n == SWAP) begin
            if (wrap_n) begin
                above_n = (row_n == '0)  ? LAST : row_n - 1'b1;
                below_n = (row_n == LAST) ? '0  : row_n + 1'b1;
            end else begin
                above_n = (row_n == '0)  ? row_n : row_n - 1'b1;
                below_n = (row_n == LAST) ? row_n : row_n + 1'b1;
                top_n   = (row_n == '0);
                bot_n   = (row_n == LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ng_q        <= '0;
            wrap_q      <= 1'b0;
            calc_flag   <= 1'b0;
            calc_row    <= '0;
            row_above   <= '0;
            row_below   <= '0;
            top_edge    <= 1'b0;
            bottom_edge <= 1'b0;
            buf_sel     <= 1'b0;
            gen_count   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            ng_q        <= ng_n;
            wrap_q      <= wrap_n;
            calc_flag   <= flag_n;
            calc_row    <= row_n;
            row_above   <= above_n;
            row_below   <= below_n;
            top_edge    <= top_n;
            bottom_edge <= bot_n;
            buf_sel     <= bsel_n;
            gen_count   <= gen_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

endmodule

// File: tb/tb_gen_row_sequencer.sv
// Scoreboard bench for gen_row_sequencer: runs are expanded into expected row/done streams
// up front and a negedge monitor pops and compares them as the DUT handshakes.
module tb_gen_row_sequencer;

    localparam int ROWS  = 4;
    localparam int ROW_W = 2;
    localparam int GEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [GEN_W-1:0] num_gens = '0;
    logic             wrap_en = 1'b0;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic             row_ack = 1'b0;
    logic             calc_flag;
    logic [ROW_W-1:0] calc_row, row_above, row_below;
    logic             top_edge, bottom_edge, buf_sel, busy, done;
    logic [GEN_W-1:0] gen_count;

    gen_row_sequencer #(.ROWS(ROWS), .ROW_W(ROW_W), .GEN_W(GEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_gens(num_gens), .wrap_en(wrap_en),
        .pause(pause), .abort(abort), .row_ack(row_ack), .calc_flag(calc_flag),
        .calc_row(calc_row), .row_above(row_above), .row_below(row_below),
        .top_edge(top_edge), .bottom_edge(bottom_edge), .buf_sel(buf_sel),
        .gen_count(gen_count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { int row; int above; int below; int top; int bot; int bsel; int gcnt; } rexp_t;
    typedef struct { int gcnt; int bsel; } dexp_t;

    rexp_t rq[$];
    dexp_t dq[$];
    int    m_buf = 0;
    int    vec = 0;
    int    err = 0;
    int    ack_mode = 0;   // 0 manual, 1 ack every offered row, 2 random ack and pause

    task automatic chk(input string nm, input int act, input int exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference: a run is N passes over rows 0..ROWS-1; buffer flips after each pass.
    function automatic void push_run(input int n, input int w);
        rexp_t e;
        dexp_t d;
        for (int g = 0; g < n; g++) begin
            for (int r = 0; r < ROWS; r++) begin
                e.row = r;
                if (w != 0) begin
                    e.above = (r + ROWS - 1) % ROWS;
                    e.below = (r + 1) % ROWS;
                    e.top = 0;
                    e.bot = 0;
                end else begin
                    e.above = (r == 0) ? 0 : r - 1;
                    e.below = (r == ROWS - 1) ? r : r + 1;
                    e.top = (r == 0) ? 1 : 0;
                    e.bot = (r == ROWS - 1) ? 1 : 0;
                end
                e.bsel = m_buf ^ (g & 1);
                e.gcnt = g;
                rq.push_back(e);
            end
        end
        d.gcnt = n;
        d.bsel = m_buf ^ (n & 1);
        m_buf = d.bsel;
        dq.push_back(d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (ack_mode == 1) begin
            row_ack = calc_flag;
        end else if (ack_mode == 2) begin
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            row_ack = calc_flag && ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic start_run(input int n, input int w);
        start = 1'b1;
        num_gens = GEN_W'(n);
        wrap_en = w[0];
        push_run(n, w);
        tick();
        start = 1'b0;
        num_gens = GEN_W'($urandom);
        wrap_en = 1'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (busy && c < budget) begin
            tick();
            c++;
        end
        chk("idle_within_budget", busy, 0);
    endtask

    // Monitor: every accepted row and every done pulse is matched against the scoreboard.
    initial forever begin
        rexp_t e;
        dexp_t d;
        @(negedge clk);
        if (rst_n) begin
            if (calc_flag && row_ack && !abort) begin
                chk("row_expected", (rq.size() > 0) ? 1 : 0, 1);
                if (rq.size() > 0) begin
                    e = rq.pop_front();
                    chk("calc_row", calc_row, e.row);
                    chk("row_above", row_above, e.above);
                    chk("row_below", row_below, e.below);
                    chk("top_edge", top_edge, e.top);
                    chk("bottom_edge", bottom_edge, e.bot);
                    chk("row_buf_sel", buf_sel, e.bsel);
                    chk("row_gen_count", gen_count, e.gcnt);
                end
            end
            if (done) begin
                chk("done_expected", (dq.size() > 0) ? 1 : 0, 1);
                if (dq.size() > 0) begin
                    d = dq.pop_front();
                    chk("done_gen_count", gen_count, d.gcnt);
                    chk("done_buf_sel", buf_sel, d.bsel);
                    chk("done_busy", busy, 1);
                end
            end
            if (!busy) chk("idle_calc_flag", calc_flag, 0);
        end
    end

    initial begin
        int b, hs, c;

        // Reset state
        #3;
        chk("rst_calc_flag", calc_flag, 0);
        chk("rst_calc_row", calc_row, 0);
        chk("rst_row_above", row_above, 0);
        chk("rst_row_below", row_below, 0);
        chk("rst_edges", {top_edge, bottom_edge}, 0);
        chk("rst_buf_sel", buf_sel, 0);
        chk("rst_gen_count", gen_count, 0);
        chk("rst_busy_done", {busy, done}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single wrapped generation, then three bounded generations
        ack_mode = 1;
        start_run(1, 1);
        wait_idle(100);
        chk("g1_gen_count", gen_count, 1);
        chk("g1_buf_sel", buf_sel, 1);
        start_run(3, 0);
        wait_idle(200);
        chk("g3_gen_count", gen_count, 3);
        chk("g3_buf_sel", buf_sel, m_buf);

        // Pause at row 2 with one acknowledge already in flight
        ack_mode = 0;
        start_run(1, 0);
        c = 0;
        while (!(calc_flag && calc_row == 2) && c < 50) begin
            row_ack = calc_flag;
            tick();
            c++;
        end
        chk("pause_reach_row2", calc_row, 2);
        pause = 1'b1;
        row_ack = 1'b1;
        tick();
        row_ack = 1'b0;
        chk("pause_flag_drop", calc_flag, 0);
        chk("pause_row_adv", calc_row, 3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pause_hold_flag", calc_flag, 0);
            chk("pause_hold_row", calc_row, 3);
        end
        pause = 1'b0;
        tick();
        chk("resume_flag", calc_flag, 1);
        chk("resume_row", calc_row, 3);
        ack_mode = 1;
        row_ack = calc_flag;
        wait_idle(100);

        // Abort at row 1 of generation 2, colliding with an acknowledge
        ack_mode = 0;
        b = m_buf;
        start_run(3, 1);
        hs = 0;
        c = 0;
        while (!(calc_flag && calc_row == 1 && hs == ROWS + 1) && c < 200) begin
            row_ack = calc_flag;
            if (calc_flag) hs++;
            tick();
            c++;
        end
        chk("abort_reach_point", hs, ROWS + 1);
        rq.delete();
        dq.delete();
        m_buf = b ^ 1;
        abort = 1'b1;
        row_ack = 1'b1;
        tick();
        abort = 1'b0;
        row_ack = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_calc_row", calc_row, 0);
        chk("abort_calc_flag", calc_flag, 0);
        chk("abort_gen_count", gen_count, 1);
        chk("abort_buf_sel", buf_sel, m_buf);
        chk("abort_no_done", done, 0);
        tick();
        tick();

        // Zero-generation run
        b = m_buf;
        start_run(0, 1);
        chk("zero_busy", busy, 1);
        chk("zero_flag", calc_flag, 0);
        tick();
        chk("zero_idle", busy, 0);
        chk("zero_flag2", calc_flag, 0);
        chk("zero_buf_sel", buf_sel, b);

        // Start pulsed mid-run is ignored
        ack_mode = 1;
        start_run(2, 1);
        tick();
        tick();
        start = 1'b1;
        num_gens = 4'd7;
        wrap_en = 1'b0;
        tick();
        start = 1'b0;
        wait_idle(200);
        chk("midstart_gen_count", gen_count, 2);

        // Randomised runs, including the full-width generation count
        ack_mode = 2;
        for (int k = 0; k < 8; k++) begin
            start_run((k == 3) ? 15 : int'($urandom_range(1, 5)), int'($urandom_range(0, 1)));
            wait_idle(3000);
            chk("rand_buf_sel", buf_sel, m_buf);
            tick();
        end
        pause = 1'b0;
        row_ack = 1'b0;

        // Asynchronous reset while in SWAP
        ack_mode = 0;
        tick();
        start_run(2, 0);
        c = 0;
        while (!(calc_flag && calc_row == ROWS - 1) && c < 50) begin
            row_ack = calc_flag;
            tick();
            c++;
        end
        row_ack = 1'b1;
        tick();
        row_ack = 1'b0;
        chk("swap_busy", busy, 1);
        chk("swap_flag", calc_flag, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_edges", {top_edge, bottom_edge}, 0);
        chk("arst_row_below", row_below, 0);
        chk("arst_buf_gen", {buf_sel, gen_count}, 0);
        rq.delete();
        dq.delete();
        m_buf = 0;
        tick();
        rst_n = 1'b1;
        tick();

        // Recovery run after reset
        ack_mode = 1;
        start_run(1, 0);
        wait_idle(100);
        chk("post_rst_buf_sel", buf_sel, 1);
        tick();
        tick();

        chk("rows_left", rq.size(), 0);
        chk("dones_left", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
